// File: rtl/dnn_folded_mlp.sv
// dnn_folded_mlp: N_IN-N_HID-N_OUT MLP (ReLU hidden layer) folded onto one signed MAC, one MAC per cycle
// Ports: clk/rst_n (async active-low); wt_we_i/wt_addr_i/wt_data_i write the weight file (IDLE/DONE only);
//        in_valid_i/in_ready_o/in_data_i accept a packed input vector; out_valid_o/out_ready_i/out_data_o/out_sat_o
//        present the packed saturated outputs with per-output clip flags; busy_o marks HID/OUT.
module dnn_folded_mlp #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int IN_W  = 5,
    parameter int WT_W  = 5,
    parameter int HID_W = 12,
    parameter int OUT_W = 17
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wt_we_i,
    input  logic [$clog2(N_IN*N_HID+N_HID*N_OUT)-1:0] wt_addr_i,
    input  logic signed [WT_W-1:0]                    wt_data_i,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [N_IN*IN_W-1:0]                      in_data_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [N_OUT*OUT_W-1:0]                    out_data_o,
    output logic [N_OUT-1:0]                          out_sat_o,
    output logic                                      busy_o
);
    localparam int NW    = N_IN*N_HID + N_HID*N_OUT;
    localparam int OPW   = IN_W > HID_W ? IN_W : HID_W;
    localparam int NMAX  = N_IN > N_HID ? (N_IN > N_OUT ? N_IN : N_OUT) : (N_HID > N_OUT ? N_HID : N_OUT);
    localparam int CW    = $clog2(NMAX + 1);
    localparam int ACC_W = OPW + WT_W + $clog2(N_IN > N_HID ? N_IN : N_HID) + 1;
    localparam longint HMAX = (longint'(1) << (HID_W-1)) - 1;
    localparam longint OMAX = (longint'(1) << (OUT_W-1)) - 1;
    localparam longint OMIN = -(longint'(1) << (OUT_W-1));

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

    state_t                    state_q, state_d;
    logic [N_IN*IN_W-1:0]      x_q, x_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]             in_q, in_d, out_q, out_d;
    logic signed [HID_W-1:0]   h_q [N_HID];
    logic signed [HID_W-1:0]   h_d [N_HID];
    logic signed [OUT_W-1:0]   y_q [N_OUT];
    logic signed [OUT_W-1:0]   y_d [N_OUT];
    logic [N_OUT-1:0]          sat_q, sat_d;
    logic signed [WT_W-1:0]    w_q [NW];
    logic signed [WT_W-1:0]    w_d [NW];

    logic                      hid, in_last, out_last;
    int                        ra;
    logic signed [OPW-1:0]     opa;
    logic signed [WT_W-1:0]    opw;
    logic signed [ACC_W-1:0]   sum;
    longint                    s;

    // Shared MAC: inner counter selects the operand, outer counter the neuron being built.
    always_comb begin
        hid      = state_q == HID;
        in_last  = int'(in_q) == (hid ? N_IN : N_HID) - 1;
        out_last = int'(out_q) == (hid ? N_HID : N_OUT) - 1;
        ra       = hid ? int'(out_q)*N_IN + int'(in_q) : N_IN*N_HID + int'(out_q)*N_HID + int'(in_q);
        opa      = '0;
        for (int n = 0; n < N_IN; n++)
            if (hid && n == int'(in_q)) opa = OPW'(signed'(x_q[n*IN_W +: IN_W]));
        for (int n = 0; n < N_HID; n++)
            if (!hid && n == int'(in_q)) opa = OPW'(h_q[n]);
        opw = '0;
        for (int n = 0; n < NW; n++)
            if (n == ra) opw = w_q[n];
        sum = acc_q + ACC_W'(opa) * ACC_W'(opw);
        s   = longint'(sum);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        in_d    = in_q;
        out_d   = out_q;
        h_d     = h_q;
        y_d     = y_q;
        sat_d   = sat_q;
        w_d     = w_q;
        for (int n = 0; n < NW; n++)
            if (wt_we_i && (state_q == IDLE || state_q == DONE) && n == int'(wt_addr_i)) w_d[n] = wt_data_i;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = HID;
                x_d     = in_data_i;
                acc_d   = '0;
                in_d    = '0;
                out_d   = '0;
            end
            HID, OUT: begin
                acc_d = in_last ? '0 : sum;
                in_d  = in_last ? '0 : in_q + 1'b1;
                out_d = in_last ? (out_last ? '0 : out_q + 1'b1) : out_q;
                if (in_last) begin
                    for (int n = 0; n < N_HID; n++)
                        if (hid && n == int'(out_q)) h_d[n] = HID_W'(s < 0 ? 64'sd0 : (s > HMAX ? HMAX : s));
                    for (int n = 0; n < N_OUT; n++)
                        if (!hid && n == int'(out_q)) begin
                            y_d[n]   = OUT_W'(s > OMAX ? OMAX : (s < OMIN ? OMIN : s));
                            sat_d[n] = s > OMAX || s < OMIN;
                        end
                    if (out_last) state_d = hid ? OUT : DONE;
                end
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
            h_q     <= '{default: '0};
            y_q     <= '{default: '0};
            sat_q   <= '0;
            w_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            in_q    <= in_d;
            out_q   <= out_d;
            h_q     <= h_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        out_data_o = '0;
        for (int n = 0; n < N_OUT; n++) out_data_o[n*OUT_W +: OUT_W] = y_q[n];
        in_ready_o  = state_q == IDLE;
        out_valid_o = state_q == DONE;
        busy_o      = state_q == HID || state_q == OUT;
        out_sat_o   = sat_q;
    end
endmodule

// File: tb/tb_dnn_folded_mlp.sv
// tb_dnn_folded_mlp: table-driven + scoreboard bench for dnn_folded_mlp (default and OUT_W=12 instances in lockstep)
module tb_dnn_folded_mlp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wt_we;
    logic [4:0]  wt_addr;
    logic [4:0]  wt_data;
    logic        in_valid;
    logic [19:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid, busy;
    logic [33:0] out_data;
    logic [1:0]  out_sat;
    logic        in_ready12, out_valid12, busy12;
    logic [23:0] out_data12;
    logic [1:0]  out_sat12;

    dnn_folded_mlp dut (
        .clk(clk), .rst_n(rst_n), .wt_we_i(wt_we), .wt_addr_i(wt_addr), .wt_data_i(wt_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_sat_o(out_sat), .busy_o(busy)
    );

    dnn_folded_mlp #(.OUT_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .wt_we_i(wt_we), .wt_addr_i(wt_addr), .wt_data_i(wt_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready12), .in_data_i(in_data),
        .out_valid_o(out_valid12), .out_ready_i(out_ready), .out_data_o(out_data12),
        .out_sat_o(out_sat12), .busy_o(busy12)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] x;
        int          hw0, hw, ow0, ow1;
        longint      y0, y1;
        logic [1:0]  s;
        longint      z0, z1;
        logic [1:0]  s12;
    } vec_t;

    typedef struct {
        longint     y0, y1;
        logic [1:0] s;
        longint     z0, z1;
        logic [1:0] s12;
    } exp_t;

    vec_t   vt [7];
    exp_t   sb [$];
    int     n_pass = 0;
    int     n_chk = 0;
    int     t0 = 0;
    logic [33:0] hold;

    function automatic logic [19:0] px(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic load(input int hw0, input int hw, input int ow0, input int ow1);
        for (int a = 0; a < 24; a++) begin
            @(negedge clk);
            wt_we   = 1'b1;
            wt_addr = 5'(a);
            wt_data = 5'(a < 4 ? hw0 : a < 16 ? hw : a < 20 ? ow0 : ow1);
        end
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    task automatic push(input longint y0, input longint y1, input logic [1:0] s,
                        input longint z0, input longint z1, input logic [1:0] s12);
        exp_t e;
        e.y0 = y0; e.y1 = y1; e.s = s; e.z0 = z0; e.z1 = z1; e.s12 = s12;
        sb.push_back(e);
    endtask

    task automatic start(input logic [19:0] x);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        t0       = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_after_accept", in_ready, 0);
        chk("busy_after_accept", busy, 1);
        chk("busy12_after_accept", busy12, 1);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        else chk("latency", cyc - t0, 24);
    endtask

    task automatic finish_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("y0", $signed(out_data[16:0]), e.y0);
        chk("y1", $signed(out_data[33:17]), e.y1);
        chk("sat", out_sat, e.s);
        chk("valid12", out_valid12, 1);
        chk("y0_w12", $signed(out_data12[11:0]), e.z0);
        chk("y1_w12", $signed(out_data12[23:12]), e.z1);
        chk("sat_w12", out_sat12, e.s12);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_in_ready12", in_ready12, 1);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        vt[0] = '{px(1,2,3,4), 1, 1, 1, 1, 40, 40, 2'b00, 40, 40, 2'b00};
        vt[1] = '{px(1,2,3,4), -1, 1, 1, 1, 30, 30, 2'b00, 30, 30, 2'b00};
        vt[2] = '{px(-16,-16,-16,-16), -16, -16, 15, 15, 61440, 61440, 2'b00, 2047, 2047, 2'b11};
        vt[3] = '{px(-16,-16,-16,-16), -16, -16, -16, -16, -65536, -65536, 2'b00, -2048, -2048, 2'b11};
        vt[4] = '{px(1,-2,3,-4), 2, 2, 1, 1, 0, 0, 2'b00, 0, 0, 2'b00};
        vt[5] = '{px(15,15,15,15), 15, 15, 1, 0, 3600, 0, 2'b00, 2047, 0, 2'b01};
        vt[6] = '{px(15,15,15,15), 15, 15, -3, -3, -10800, -10800, 2'b00, -2048, -2048, 2'b11};
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            load(vt[v].hw0, vt[v].hw, vt[v].ow0, vt[v].ow1);
            push(vt[v].y0, vt[v].y1, vt[v].s, vt[v].z0, vt[v].z1, vt[v].s12);
            start(vt[v].x);
            wait_out();
            finish_out();
        end

        // Backpressure: result held, in_valid ignored while DONE
        load(1, 1, 1, 1);
        push(40, 40, 2'b00, 40, 40, 2'b00);
        start(px(1,2,3,4));
        wait_out();
        hold = out_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_data_stable", out_data, hold);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            in_valid = (c == 4);
            in_data  = px(5,5,5,5);
        end
        in_valid = 1'b0;
        finish_out();
        chk("bp_no_restart", busy, 0);

        // Weight write on the accepting edge is used by that computation
        push(42, 42, 2'b00, 42, 42, 2'b00);
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 5'd0; wt_data = 5'd3;
        in_valid = 1'b1; in_data = px(1,2,3,4);
        t0 = cyc + 1;
        @(negedge clk);
        wt_we = 1'b0; in_valid = 1'b0;
        wait_out();
        finish_out();

        // Writes during HID are dropped
        push(42, 42, 2'b00, 42, 42, 2'b00);
        start(px(1,2,3,4));
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 5'd0; wt_data = 5'h1b;
        repeat (3) @(negedge clk);
        wt_we = 1'b0;
        wait_out();
        finish_out();

        // Out-of-range address is ignored
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 5'd24; wt_data = 5'h1b;
        @(negedge clk);
        wt_we = 1'b0;
        push(42, 42, 2'b00, 42, 42, 2'b00);
        start(px(1,2,3,4));
        wait_out();
        finish_out();

        // Reset mid-HID aborts and clears weights
        start(px(1,2,3,4));
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", out_data, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 2'b00, 0, 0, 2'b00);
        start(px(1,2,3,4));
        wait_out();
        finish_out();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
